// File: rtl/fpga.sv
// rtl/fpga.sv - 16-node round-robin arbitrated serial bus transmitter
module fpga (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
    input  logic [3:0]  CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
    input  logic [63:0] Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
    input  logic [63:0] Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16,
    input  logic [3:0]  addr1, addr2, addr3, addr4, addr5, addr6, addr7, addr8,
    input  logic [3:0]  addr9, addr10, addr11, addr12, addr13, addr14, addr15, addr16,
    input  logic [3:0]  receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
    input  logic [3:0]  receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
    input  logic [3:0]  receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
    input  logic [3:0]  receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
    input  logic [1:0]  mod1, mod2, mod3, mod4, mod5, mod6, mod7, mod8,
    input  logic [1:0]  mod9, mod10, mod11, mod12, mod13, mod14, mod15, mod16,
    output logic        bus_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // Node inputs gathered into arrays indexed 0..15 (node1 at index 0)
    logic [3:0]  crc_a  [16];
    logic [63:0] data_a [16];
    logic [3:0]  addr_a [16];
    logic [3:0]  rcv_a  [16];
    logic [1:0]  mod_a  [16];

    assign crc_a  = '{CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
                      CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16};
    assign data_a = '{Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
                      Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16};
    assign addr_a = '{addr1, addr2, addr3, addr4, addr5, addr6, addr7, addr8,
                      addr9, addr10, addr11, addr12, addr13, addr14, addr15, addr16};
    assign rcv_a  = '{receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
                      receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
                      receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
                      receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16};
    assign mod_a  = '{mod1, mod2, mod3, mod4, mod5, mod6, mod7, mod8,
                      mod9, mod10, mod11, mod12, mod13, mod14, mod15, mod16};

    logic [1:0]  state;
    logic [6:0]  bit_cnt;
    logic [79:0] shreg;
    logic [3:0]  ptr;
    logic [3:0]  win_q;

    logic [15:0] req;
    logic        any_req;
    logic [3:0]  win;
    logic [3:0]  idx;
    logic [3:0]  dest;
    logic [79:0] next_frame;

    // Request decode: modes 1 (unicast) and 2 (broadcast) are requests
    always_comb begin
        req = '0;
        for (int n = 0; n < 16; n++) begin
            req[n] = (mod_a[n] == 2'd1) || (mod_a[n] == 2'd2);
        end
    end

    // Round-robin search; scanning from the far end lets the nearest requester win last
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = '0;
        for (int k = 15; k >= 0; k--) begin
            idx = ptr + 4'(k);
            if (req[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

    // Frame assembly draws only from the winner, so idle nodes' inputs never matter
    always_comb begin
        dest       = (mod_a[win] == 2'd2) ? 4'hF : rcv_a[win];
        next_frame = {1'b0, addr_a[win], dest, mod_a[win], data_a[win], crc_a[win], 1'b1};
    end

    // Transmit FSM: latch frame on grant, shift one bit per clock, one idle-high gap
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            bus_out <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            win_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus_out <= 1'b1;
                    if (any_req) begin
                        bus_out <= next_frame[79];
                        shreg   <= {next_frame[78:0], 1'b0};
                        win_q   <= win;
                        bit_cnt <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt == 7'd79) begin
                        bus_out <= 1'b1;
                        ptr     <= win_q + 4'd1;
                        bit_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        bus_out <= shreg[79];
                        shreg   <= {shreg[78:0], 1'b0};
                        bit_cnt <= bit_cnt + 7'd1;
                    end
                end
                GAP: begin
                    bus_out <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    bus_out <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga.sv
// tb/tb_fpga.sv - randomized and directed self-checking bench for fpga
module tb_fpga;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  crc  [1:16];
    logic [63:0] data [1:16];
    logic [3:0]  addr [1:16];
    logic [3:0]  rcv  [1:16];
    logic [1:0]  mod  [1:16];
    logic        bus_out;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ptr  = 0;

    always #5 clock = ~clock;

    fpga dut (
        .clock(clock), .reset(reset),
        .CRC1(crc[1]), .CRC2(crc[2]), .CRC3(crc[3]), .CRC4(crc[4]),
        .CRC5(crc[5]), .CRC6(crc[6]), .CRC7(crc[7]), .CRC8(crc[8]),
        .CRC9(crc[9]), .CRC10(crc[10]), .CRC11(crc[11]), .CRC12(crc[12]),
        .CRC13(crc[13]), .CRC14(crc[14]), .CRC15(crc[15]), .CRC16(crc[16]),
        .Data1(data[1]), .Data2(data[2]), .Data3(data[3]), .Data4(data[4]),
        .Data5(data[5]), .Data6(data[6]), .Data7(data[7]), .Data8(data[8]),
        .Data9(data[9]), .Data10(data[10]), .Data11(data[11]), .Data12(data[12]),
        .Data13(data[13]), .Data14(data[14]), .Data15(data[15]), .Data16(data[16]),
        .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]), .addr4(addr[4]),
        .addr5(addr[5]), .addr6(addr[6]), .addr7(addr[7]), .addr8(addr[8]),
        .addr9(addr[9]), .addr10(addr[10]), .addr11(addr[11]), .addr12(addr[12]),
        .addr13(addr[13]), .addr14(addr[14]), .addr15(addr[15]), .addr16(addr[16]),
        .receiverAddr1(rcv[1]), .receiverAddr2(rcv[2]), .receiverAddr3(rcv[3]),
        .receiverAddr4(rcv[4]), .receiverAddr5(rcv[5]), .receiverAddr6(rcv[6]),
        .receiverAddr7(rcv[7]), .receiverAddr8(rcv[8]), .receiverAddr9(rcv[9]),
        .receiverAddr10(rcv[10]), .receiverAddr11(rcv[11]), .receiverAddr12(rcv[12]),
        .receiverAddr13(rcv[13]), .receiverAddr14(rcv[14]), .receiverAddr15(rcv[15]),
        .receiverAddr16(rcv[16]),
        .mod1(mod[1]), .mod2(mod[2]), .mod3(mod[3]), .mod4(mod[4]),
        .mod5(mod[5]), .mod6(mod[6]), .mod7(mod[7]), .mod8(mod[8]),
        .mod9(mod[9]), .mod10(mod[10]), .mod11(mod[11]), .mod12(mod[12]),
        .mod13(mod[13]), .mod14(mod[14]), .mod15(mod[15]), .mod16(mod[16]),
        .bus_out(bus_out)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference arbitration: first requesting node at or after the pointer (1-based result)
    function automatic int pick();
        for (int k = 0; k < 16; k++) begin
            int n;
            n = ((exp_ptr + k) % 16) + 1;
            if (mod[n] == 2'd1 || mod[n] == 2'd2) return n;
        end
        return 0;
    endfunction

    // Reference frame: fields pushed MSB-first onto a bit list, then packed
    function automatic logic [79:0] build(input int n);
        bit q[$];
        logic [79:0] f;
        logic [3:0] d;
        d = (mod[n] == 2'd2) ? 4'hF : rcv[n];
        q.push_back(1'b0);
        for (int b = 3; b >= 0; b--) q.push_back(addr[n][b]);
        for (int b = 3; b >= 0; b--) q.push_back(d[b]);
        for (int b = 1; b >= 0; b--) q.push_back(mod[n][b]);
        for (int b = 63; b >= 0; b--) q.push_back(data[n][b]);
        for (int b = 3; b >= 0; b--) q.push_back(crc[n][b]);
        q.push_back(1'b1);
        for (int i = 0; i < 80; i++) f[79 - i] = q[i];
        return f;
    endfunction

    task automatic randomize_nodes();
        for (int n = 1; n <= 16; n++) begin
            data[n] = {$urandom, $urandom};
            crc[n]  = 4'($urandom);
            addr[n] = 4'($urandom);
            rcv[n]  = 4'($urandom);
            mod[n]  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ptr = 0;
    endtask

    // Checks one frame starting from IDLE: 80 bits, then gap and idle cycles high.
    // mut_at >= 0 changes inputs after that bit: all nodes randomized or Data1 set to ones.
    task automatic check_frame(input string tag, input int mut_at, input bit mut_all);
        int w;
        logic [79:0] expf, got;
        logic [79:0] tail;
        w = pick();
        expf = build(w);
        got = '0;
        for (int i = 0; i < 80; i++) begin
            tick();
            got[79 - i] = bus_out;
            if (i == mut_at) begin
                if (mut_all) randomize_nodes();
                else data[1] = '1;
            end
        end
        chk(tag, got, expf);
        tail = '0;
        tick();
        tail[1] = bus_out;
        tick();
        tail[0] = bus_out;
        chk({tag, "_gap"}, tail, 80'd3);
        exp_ptr = w % 16;
    endtask

    task automatic check_idle(input string tag, input int cycles);
        int ones;
        ones = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus_out === 1'b1) ones++;
        end
        chk(tag, 80'(ones), 80'(cycles));
    endtask

    initial begin
        logic [79:0] expf, got;
        int w, any;
        reset = 1'b0;
        for (int n = 1; n <= 16; n++) mod[n] = 2'd0;

        // Reset state and long idle with no requests; other node inputs left as X
        do_reset();
        chk("reset_bus", 80'(bus_out), 80'd1);
        check_idle("idle_200", 200);

        // Node1 unicast, repeated frames every 82 cycles
        addr[1] = 4'd0; rcv[1] = 4'd1; data[1] = 64'd1; crc[1] = 4'd1; mod[1] = 2'd1;
        expf = {1'b0, 4'b0000, 4'b0001, 2'b01, 64'd1, 4'b0001, 1'b1};
        w = pick();
        chk("node1_model", build(w), expf);
        check_frame("node1_f1", -1, 1'b0);
        check_frame("node1_f2", -1, 1'b0);

        // Frame immunity: Data1 goes to all-ones mid-frame
        check_frame("immune_cur", 40, 1'b0);
        check_frame("immune_next", -1, 1'b0);

        // Reset at bit 30 while node2 is winning; pointer must return to node1
        addr[2] = 4'd1; rcv[2] = 4'd7; data[2] = 64'hA5A5_0F0F_1234_5678; crc[2] = 4'hC; mod[2] = 2'd1;
        w = pick();
        expf = build(w);
        got = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            got[79 - i] = bus_out;
        end
        chk("abort_prefix", got[79:50], expf[79:50]);
        do_reset();
        chk("abort_bus_high", 80'(bus_out), 80'd1);
        check_frame("after_abort", -1, 1'b0);

        // Contention from reset: node1, node2, node1
        data[1] = 64'h0123_4567_89AB_CDEF;
        do_reset();
        check_frame("cont_n1", -1, 1'b0);
        check_frame("cont_n2", -1, 1'b0);
        check_frame("cont_n1b", -1, 1'b0);

        // Broadcast from node3 only
        for (int n = 1; n <= 16; n++) mod[n] = 2'd0;
        addr[3] = 4'd2; rcv[3] = 4'd5; data[3] = 64'hFFFF_0000_FFFF_0000; crc[3] = 4'h9; mod[3] = 2'd2;
        do_reset();
        check_frame("bcast", -1, 1'b0);

        // Randomized traffic, some with inputs scrambled mid-frame
        for (int r = 0; r < 16; r++) begin
            randomize_nodes();
            any = pick();
            if (any == 0) check_idle("rand_idle", 4);
            else check_frame("rand", ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 78)) : -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
